// File: rtl/mem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter_if
// Desc     : Request/response bundle for two clients plus the shared RAM port.
// Revision : 1.0  initial release
// ============================================================================
interface mem_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int MEM_WIDTH  = 4
);
  logic                  valid0;
  logic                  wr0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [MEM_WIDTH-1:0]  indata0;
  logic                  ready0;

  logic                  valid1;
  logic                  wr1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [MEM_WIDTH-1:0]  indata1;
  logic                  ready1;

  logic [MEM_WIDTH-1:0]  rsp_data;
  logic                  rsp_err;

  logic                  mem_valid;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_indata;
  logic                  mem_ready;
  logic [MEM_WIDTH-1:0]  mem_outdata;

  // Client and RAM side of the bundle.
  modport master (
    output valid0, wr0, addr0, indata0,
    output valid1, wr1, addr1, indata1,
    input  ready0, ready1, rsp_data, rsp_err,
    input  mem_valid, mem_wr, mem_addr, mem_indata,
    output mem_ready, mem_outdata
  );

  // Arbiter side of the bundle.
  modport slave (
    input  valid0, wr0, addr0, indata0,
    input  valid1, wr1, addr1, indata1,
    output ready0, ready1, rsp_data, rsp_err,
    output mem_valid, mem_wr, mem_addr, mem_indata,
    input  mem_ready, mem_outdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Desc     : Shares one valid/ready RAM port between two requesters.
//            Define ARB_FIXED_PRIO_EN for fixed req0 priority; default is round-robin.
// Revision : 1.0  initial release
// ============================================================================
module mem_rr_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int MEM_WIDTH  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic            clk,
  input  logic            rst,
  mem_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] c_CNT_LAST = 4'(TIMEOUT - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_last;
  logic                  r_gnt;
  logic                  r_ready0;
  logic                  r_ready1;
  logic [MEM_WIDTH-1:0]  r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_mem_valid;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [MEM_WIDTH-1:0]  r_mem_indata;

  logic                  w_any_valid;
  logic                  w_gnt;

  assign w_any_valid = bus.valid0 | bus.valid1;

`ifdef ARB_FIXED_PRIO_EN
  assign w_gnt = ~bus.valid0;
`else
  // On a tie the requester that did not win last time goes next.
  assign w_gnt = (bus.valid0 & bus.valid1) ? ~r_last : bus.valid1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_indata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_gnt        <= w_gnt;
            r_last       <= w_gnt;
            r_mem_valid  <= 1'b1;
            r_mem_wr     <= w_gnt ? bus.wr1     : bus.wr0;
            r_mem_addr   <= w_gnt ? bus.addr1   : bus.addr0;
            r_mem_indata <= w_gnt ? bus.indata1 : bus.indata0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_valid <= 1'b0;
          r_cnt       <= 4'd0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_ready) begin
            r_rsp_data <= r_mem_wr ? '0 : bus.mem_outdata;
            r_rsp_err  <= 1'b0;
            r_ready0   <= ~r_gnt;
            r_ready1   <= r_gnt;
            r_state    <= S_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_ready0   <= ~r_gnt;
            r_ready1   <= r_gnt;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          // No arbitration here, so a held valid waits for the next IDLE.
          r_ready0 <= 1'b0;
          r_ready1 <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready0     = r_ready0;
  assign bus.ready1     = r_ready1;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.mem_valid  = r_mem_valid;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_indata = r_mem_indata;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rr_arbiter
// Desc     : Directed and randomized bench for mem_rr_arbiter with a RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_rr_arbiter;

  localparam int c_AW    = 2;
  localparam int c_MW    = 4;
  localparam int c_TO    = 8;
  localparam int c_DEPTH = 1 << c_AW;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [c_MW-1:0] ram_q   [c_DEPTH];
  logic [c_MW-1:0] ref_mem [c_DEPTH];
  bit   ram_inited = 1'b0;
  bit   ram_en     = 1'b1;
  bit   ram_armed  = 1'b0;
  int   ram_delay  = 0;
  int   ram_cd     = 0;
  int   m_last     = 1;
  logic prev_mv    = 1'b0;

  mem_rr_arbiter_if #(.ADDR_WIDTH(c_AW), .MEM_WIDTH(c_MW)) bus ();

  mem_rr_arbiter #(
    .ADDR_WIDTH(c_AW),
    .MEM_WIDTH (c_MW),
    .TIMEOUT   (c_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM: access at the negedge of the mem_valid cycle, answer ram_delay cycles later
  always @(negedge clk) begin
    if (rst) begin
      if (!ram_inited) begin
        for (int i = 0; i < c_DEPTH; i++) ram_q[i] = '0;
        ram_inited = 1'b1;
      end
      bus.mem_ready   = 1'b0;
      bus.mem_outdata = '0;
      ram_armed       = 1'b0;
      ram_cd          = 0;
    end else begin
      bus.mem_ready = 1'b0;
      if (bus.mem_valid) begin
        if (ram_en) begin
          if (bus.mem_wr) ram_q[bus.mem_addr] = bus.mem_indata;
          else            bus.mem_outdata     = ram_q[bus.mem_addr];
          ram_armed = 1'b1;
          ram_cd    = ram_delay;
        end
      end else if (ram_armed) begin
        if (ram_cd == 0) begin
          bus.mem_ready = 1'b1;
          ram_armed     = 1'b0;
        end else begin
          ram_cd--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("ready_onehot", 32'(bus.ready0 & bus.ready1), 32'd0);
      chk("mem_valid_b2b", 32'(bus.mem_valid & prev_mv), 32'd0);
    end
    prev_mv = bus.mem_valid;
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready0"},     32'(bus.ready0),     32'd0);
    chk({tag, "_ready1"},     32'(bus.ready1),     32'd0);
    chk({tag, "_rsp_data"},   32'(bus.rsp_data),   32'd0);
    chk({tag, "_rsp_err"},    32'(bus.rsp_err),    32'd0);
    chk({tag, "_mem_valid"},  32'(bus.mem_valid),  32'd0);
    chk({tag, "_mem_wr"},     32'(bus.mem_wr),     32'd0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({tag, "_mem_indata"}, 32'(bus.mem_indata), 32'd0);
  endtask

  task automatic new_req(input int r);
    if (r == 0) begin
      bus.valid0 = 1'b1; bus.wr0 = 1'($urandom_range(0, 1));
      bus.addr0 = c_AW'($urandom); bus.indata0 = c_MW'($urandom);
    end else begin
      bus.valid1 = 1'b1; bus.wr1 = 1'($urandom_range(0, 1));
      bus.addr1 = c_AW'($urandom); bus.indata1 = c_MW'($urandom);
    end
  endtask

  task automatic new_read(input int r);
    if (r == 0) begin
      bus.valid0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = c_AW'($urandom);
    end else begin
      bus.valid1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = c_AW'($urandom);
    end
  endtask

  task automatic drop(input int r);
    if (r == 0) bus.valid0 = 1'b0;
    else        bus.valid1 = 1'b0;
  endtask

  // Called at the negedge of an IDLE cycle with the request(s) already driven.
  // mode 0: winner drops valid after ready; 1: winner issues a new read; 2: random.
  task automatic do_txn(input int mode, output int gnt, output logic [c_MW-1:0] data,
                        output logic err);
    int g;
    logic w;
    logic [c_AW-1:0] a;
    logic [c_MW-1:0] d;
    logic [c_MW-1:0] exp_d;
    logic exp_e;
    int lat;
    int exp_lat;
    bit got;
`ifdef ARB_FIXED_PRIO_EN
    g = bus.valid0 ? 0 : 1;
`else
    if (bus.valid0 && bus.valid1) g = (m_last == 0) ? 1 : 0;
    else                          g = bus.valid0 ? 0 : 1;
`endif
    m_last = g;
    if (g == 0) begin w = bus.wr0; a = bus.addr0; d = bus.indata0; end
    else        begin w = bus.wr1; a = bus.addr1; d = bus.indata1; end
    exp_e = !ram_en;
    exp_d = '0;
    if (ram_en) begin
      if (w) ref_mem[a] = d;
      else   exp_d = ref_mem[a];
    end
    exp_lat = ram_en ? 3 + ram_delay : c_TO + 2;

    @(negedge clk);
    chk("issue_valid",  32'(bus.mem_valid),  32'd1);
    chk("issue_wr",     32'(bus.mem_wr),     32'(w));
    chk("issue_addr",   32'(bus.mem_addr),   32'(a));
    chk("issue_indata", 32'(bus.mem_indata), 32'(d));
    if (mode == 2) begin
      // fields move after grant; the latched copy must be what completes
      if (g == 0) begin bus.wr0 = ~bus.wr0; bus.addr0 = c_AW'($urandom); bus.indata0 = c_MW'($urandom); end
      else        begin bus.wr1 = ~bus.wr1; bus.addr1 = c_AW'($urandom); bus.indata1 = c_MW'($urandom); end
      if ($urandom_range(0, 2) == 0) begin
        if (g == 0 && !bus.valid1) new_req(1);
        if (g == 1 && !bus.valid0) new_req(0);
      end
    end

    lat = 1;
    got = 1'b0;
    for (int k = 0; k < c_TO + 6 && !got; k++) begin
      @(negedge clk);
      lat++;
      got = bus.ready0 | bus.ready1;
    end
    chk("ready_seen", 32'(got),          32'd1);
    chk("ready_lat",  32'(lat),          32'(exp_lat));
    chk("ready0",     32'(bus.ready0),   32'(g == 0));
    chk("ready1",     32'(bus.ready1),   32'(g == 1));
    chk("rsp_data",   32'(bus.rsp_data), 32'(exp_d));
    chk("rsp_err",    32'(bus.rsp_err),  32'(exp_e));
    gnt  = bus.ready1 ? 1 : 0;
    data = bus.rsp_data;
    err  = bus.rsp_err;

    case (mode)
      0:       drop(g);
      1:       new_read(g);
      default: if ($urandom_range(0, 1) == 1) new_req(g); else drop(g);
    endcase

    @(negedge clk);
    chk("idle_no_issue", 32'(bus.mem_valid),            32'd0);
    chk("idle_no_ready", 32'(bus.ready0 | bus.ready1), 32'd0);
    chk("rsp_hold",      32'(bus.rsp_data),             32'(exp_d));
  endtask

  task automatic drain();
    int g;
    logic [c_MW-1:0] dv;
    logic ev;
    for (int i = 0; i < 4 && (bus.valid0 || bus.valid1); i++) do_txn(0, g, dv, ev);
  endtask

  initial begin
    int g;
    logic [c_MW-1:0] dv;
    logic ev;
    int exp_order [4];

    rst = 1'b1;
    bus.valid0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.indata0 = '0;
    bus.valid1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.indata1 = '0;
    for (int i = 0; i < c_DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    m_last = 1;

    // write A to address 2 from req0
    bus.valid0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd2; bus.indata0 = 4'hA;
    do_txn(0, g, dv, ev);
    chk("t1_gnt", 32'(g), 32'd0);
    chk("t1_err", 32'(ev), 32'd0);

    // read it back from req1
    bus.valid1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 2'd2;
    do_txn(0, g, dv, ev);
    chk("t2_gnt",  32'(g),  32'd1);
    chk("t2_data", 32'(dv), 32'hA);
    chk("t2_err",  32'(ev), 32'd0);

    // both held high from a fresh reset: grant order
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1;
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    new_read(0);
    new_read(1);
    for (int i = 0; i < 4; i++) begin
      do_txn(1, g, dv, ev);
      chk("order_gnt", 32'(g), 32'(exp_order[i]));
    end
    drain();

    // RAM never answers: timeout completion
    ram_en = 1'b0;
    bus.valid0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 2'd1;
    do_txn(0, g, dv, ev);
    chk("to_gnt",  32'(g),  32'd0);
    chk("to_err",  32'(ev), 32'd1);
    chk("to_data", 32'(dv), 32'd0);

    // reset while req0 waits, req1 pending
    bus.valid0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 2'd3;
    @(negedge clk);
    chk("rstw_issue", 32'(bus.mem_valid), 32'd1);
    chk("rstw_addr",  32'(bus.mem_addr),  32'd3);
    bus.valid1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 2'd2;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("rst_async");
    bus.valid0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ready", 32'(bus.ready0 | bus.ready1), 32'd0);
    end
    rst = 1'b0;
    m_last = 1;
    ram_en = 1'b1;
    ram_delay = 0;
    do_txn(0, g, dv, ev);
    chk("rstw_gnt",  32'(g),  32'd1);
    chk("rstw_data", 32'(dv), 32'hA);

    // valid0 held across ready0 with new fields: back-to-back grant
    bus.valid0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd1; bus.indata0 = 4'h5;
    do_txn(1, g, dv, ev);
    chk("held_gnt1", 32'(g), 32'd0);
    do_txn(0, g, dv, ev);
    chk("held_gnt2", 32'(g), 32'd0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      ram_delay = $urandom_range(0, 3);
      if (!bus.valid0 && !bus.valid1) begin
        new_req($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) new_req($urandom_range(0, 1));
      end
      do_txn(2, g, dv, ev);
    end
    ram_delay = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
